// File: rtl/mem_arbiter_pkg.sv
// beta_mem_pkg: shared FSM state, owner encoding and default latency for mem_arbiter
package beta_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam int DEF_MEM_LAT = 2;
endpackage

// File: rtl/mem_arbiter_prio.sv
// mem_arb_prio: fetch/data grant selection with optional starvation guard (MEM_ARB_STARVE_GUARD_EN)
// Ports: clk, rst; i_if_req, i_d_req requests; i_grant strobe when a grant is taken; o_owner chosen requester.
module mem_arb_prio
  import beta_mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_if_req,
  input  logic   i_d_req,
  input  logic   i_grant,
  output owner_t o_owner
);
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve;
  logic          w_force_if;
  // Counts data grants taken over a waiting fetch; at the limit the fetch wins once.
  assign w_force_if = i_if_req && (r_starve == SW'(STARVE_LIMIT));
  assign o_owner = (i_d_req && !w_force_if) ? OWN_D : OWN_IF;
  always_ff @(posedge clk) begin
    if (rst) r_starve <= '0;
    else if (i_grant) r_starve <= (o_owner == OWN_IF) ? '0 : i_if_req ? r_starve + 1'b1 : r_starve;
  end
`else
  logic w_unused;
  assign w_unused = ^{clk, rst, i_grant, i_if_req};
  assign o_owner = i_d_req ? OWN_D : OWN_IF;
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and data requesters (optional MEM_ARB_STARVE_GUARD_EN)
// Ports: clk, rst; if_req/if_addr -> if_rdata/if_ack fetch side; d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack data side;
// mem_addr/mem_wdata/mem_we/mem_oe -> memory, mem_rdata <- memory; stall_fetch = if_req & ~if_ack.
module mem_arbiter
  import beta_mem_pkg::*;
#(
  parameter int MEM_LAT      = DEF_MEM_LAT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_oe,
  input  logic [31:0] mem_rdata,
  output logic        stall_fetch
);
  localparam int CW = $clog2(MEM_LAT + 1);
  state_t        r_state;
  owner_t        r_owner;
  logic          r_we;
  logic [CW-1:0] r_lat_cnt;
  logic [31:0]   r_mem_addr, r_mem_wdata, r_if_rdata, r_d_rdata;
  logic          r_mem_oe, r_mem_we, r_if_ack, r_d_ack;
  logic          w_grant_ev, w_store;
  owner_t        w_owner;
  assign w_grant_ev = (r_state == IDLE) && (if_req || d_req);
  assign w_store = (w_owner == OWN_D) && d_we;
  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk      (clk),
    .rst      (rst),
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .i_grant  (w_grant_ev),
    .o_owner  (w_owner)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_lat_cnt   <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_mem_oe    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
    end else begin
      r_mem_oe <= 1'b0;
      r_mem_we <= 1'b0;
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        IDLE: if (w_grant_ev) begin
          r_owner    <= w_owner;
          r_we       <= w_store;
          r_mem_addr <= (w_owner == OWN_D) ? d_addr : if_addr;
          if (w_store) r_mem_wdata <= d_wdata;
          r_mem_we   <= w_store;
          r_mem_oe   <= !w_store;
          r_state    <= ISSUE;
        end
        ISSUE: if (r_we) begin
          r_d_ack <= 1'b1;
          r_state <= RESP;
        end else begin
          // Count 0 in WAIT marks the cycle mem_rdata is valid (MEM_LAT cycles after the command).
          r_lat_cnt <= CW'(MEM_LAT - 1);
          r_state   <= WAIT;
        end
        WAIT: if (r_lat_cnt == '0) begin
          if (r_owner == OWN_D) begin
            r_d_rdata <= mem_rdata;
            r_d_ack   <= 1'b1;
          end else begin
            r_if_rdata <= mem_rdata;
            r_if_ack   <= 1'b1;
          end
          r_state <= RESP;
        end else r_lat_cnt <= r_lat_cnt - 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_oe      = r_mem_oe;
  assign mem_we      = r_mem_we;
  assign if_rdata    = r_if_rdata;
  assign d_rdata     = r_d_rdata;
  assign if_ack      = r_if_ack;
  assign d_ack       = r_d_ack;
  assign stall_fetch = if_req & ~r_if_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-accurate memory model
module tb_mem_arbiter;
  localparam int L  = 2;
  localparam int SL = 4;
  logic clk = 0, rst = 1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_ack, d_ack, mem_we, mem_oe, stall_fetch;
  int cyc = 0, n_chk = 0, n_pass = 0;
  logic [31:0] pipe [L];
  logic [31:0] darr [16];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_if [$];
  logic [31:0] exp_d [$];
  logic [31:0] last_d = 0, e;
  bit pend = 0, pend_d, prev_if, prev_d, own_d, exp_own_d;
  bit glog [$];
  int ack_at, starve = 0, cmd_if, cmd_d, ack_if, ack_d, t;

  mem_arbiter #(.MEM_LAT(L), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_rdata(mem_rdata), .stall_fetch(stall_fetch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] hashf(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  function automatic logic [31:0] mem_init(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : hashf(a);
  endfunction
  function automatic void chk(bit ok, string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Memory: data region 0x00..0x3F is writable, everything else is a fixed pattern.
  // Read data appears exactly L cycles after the command; other cycles carry junk.
  initial begin
    for (int i = 0; i < 16; i++) darr[i] = hashf(32'(i * 4));
    forever begin
      @(posedge clk);
      if (mem_we && mem_addr < 32'h40) darr[mem_addr[5:2]] = mem_wdata;
      pipe[0] <= mem_oe ? ((mem_addr < 32'h40) ? darr[mem_addr[5:2]] : mem_init(mem_addr)) : $urandom;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign mem_rdata = pipe[L-1];

  // Monitor: command legality, arbitration rule, ack timing, and data from the scoreboard queues.
  initial forever begin
    @(negedge clk);
    chk(stall_fetch == (if_req & ~if_ack), "stall_fetch", 32'(stall_fetch), 32'(if_req & ~if_ack));
    if (rst) begin
      pend = 0;
      starve = 0;
    end else begin
      if (mem_oe || mem_we) begin
        own_d = mem_we || (d_req && !d_we && mem_addr == d_addr);
        chk(!(mem_oe && mem_we), "oe_we_excl", {30'd0, mem_oe, mem_we}, 0);
        chk(!pend, "cmd_overlap", 32'(pend), 0);
        chk(own_d ? (d_req && mem_addr == d_addr) : (if_req && mem_addr == if_addr), "cmd_addr", mem_addr, own_d ? d_addr : if_addr);
        if (mem_we) chk(d_we && mem_wdata == d_wdata, "cmd_wdata", mem_wdata, d_wdata);
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_own_d = prev_d && !(prev_if && starve == SL);
`else
        exp_own_d = prev_d;
`endif
        chk(own_d == exp_own_d, "grant_owner", 32'(own_d), 32'(exp_own_d));
        starve = own_d ? starve + int'(prev_if) : 0;
        glog.push_back(own_d);
        if (own_d) cmd_d = cyc; else cmd_if = cyc;
        pend = 1;
        pend_d = own_d;
        ack_at = cyc + (mem_we ? 1 : L + 1);
      end
      if (if_ack || d_ack) begin
        chk(pend && cyc == ack_at && d_ack == pend_d && !(if_ack && d_ack), "ack_timing", cyc, ack_at);
        pend = 0;
        if (d_ack) begin
          ack_d = cyc;
          if (exp_d.size() == 0) chk(0, "d_ack_unexpected", d_rdata, 0);
          else begin
            e = exp_d.pop_front();
            chk(d_rdata == e, "d_rdata", d_rdata, e);
          end
        end
        if (if_ack) begin
          ack_if = cyc;
          if (exp_if.size() == 0) chk(0, "if_ack_unexpected", if_rdata, 0);
          else begin
            e = exp_if.pop_front();
            chk(if_rdata == e, "if_rdata", if_rdata, e);
          end
        end
      end else if (pend && cyc > ack_at) begin
        chk(0, "ack_missing", cyc, ack_at);
        pend = 0;
      end
    end
    prev_if = if_req;
    prev_d = d_req;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns #1 after the edge following the ack, when the requester may change its request.
  task automatic wait_ack(input bit d);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(d ? d_ack : if_ack) && n < 200);
    if (n >= 200) chk(0, d ? "d_ack_timeout" : "if_ack_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk(input string nm);
    chk({if_ack, d_ack, mem_oe, mem_we} == 4'b0, {nm, "_strobes"}, {28'd0, if_ack, d_ack, mem_oe, mem_we}, 0);
    chk(mem_addr == 0, {nm, "_mem_addr"}, mem_addr, 0);
    chk(mem_wdata == 0, {nm, "_mem_wdata"}, mem_wdata, 0);
    chk(if_rdata == 0, {nm, "_if_rdata"}, if_rdata, 0);
    chk(d_rdata == 0, {nm, "_d_rdata"}, d_rdata, 0);
  endtask

  task automatic push_d(input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_req = 1;
    if (we) begin
      ref_mem[a[5:2]] = wd;
      exp_d.push_back(last_d);
    end else begin
      last_d = (a < 32'h40) ? ref_mem[a[5:2]] : mem_init(a);
      exp_d.push_back(last_d);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = hashf(32'(i * 4));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_chk("reset");
    @(posedge clk);
    #1 rst = 0;
    t = cyc;
    if_addr = 32'h100;
    if_req = 1;
    exp_if.push_back(32'hDEADBEEF);
    wait_ack(0);
    if_req = 0;
    chk(cmd_if == t + 1, "fetch_cmd_cycle", cmd_if, t + 1);
    chk(ack_if == t + 2 + L, "fetch_ack_cycle", ack_if, t + 2 + L);
    t = cyc;
    if_addr = 32'h200;
    if_req = 1;
    exp_if.push_back(mem_init(32'h200));
    push_d(0, 32'h400, 0);
    fork
      begin wait_ack(1); d_req = 0; end
      begin wait_ack(0); if_req = 0; end
    join
    chk(cmd_d == t + 1, "both_d_cmd", cmd_d, t + 1);
    chk(ack_d == t + 2 + L, "both_d_ack", ack_d, t + 2 + L);
    chk(cmd_if == t + 4 + L, "both_if_cmd", cmd_if, t + 4 + L);
    chk(ack_if == t + 5 + 2 * L, "both_if_ack", ack_if, t + 5 + 2 * L);
    t = cyc;
    push_d(1, 32'h10, 32'h12345678);
    wait_ack(1);
    d_req = 0;
    chk(cmd_d == t + 1, "store_cmd", cmd_d, t + 1);
    chk(ack_d == t + 2, "store_ack", ack_d, t + 2);
    push_d(0, 32'h10, 0);
    wait_ack(1);
    d_req = 0;
    t = cyc;
    push_d(0, 32'h20, 0);
    idle(2);
    rst = 1;
    d_req = 0;
    @(posedge clk);
    @(negedge clk);
    reset_chk("mid_reset");
    exp_d.delete();
    last_d = 0;
    @(posedge clk);
    #1 rst = 0;
    idle(3 * L + 6);
    if_addr = 32'h2000_0000;
    if_req = 1;
    exp_if.push_back(mem_init(if_addr));
    push_d(0, 32'h404, 0);
    glog.delete();
    t = 0;
    while (glog.size() < 10 && t < 400) begin
      @(negedge clk);
      t++;
      if (if_ack) exp_if.push_back(mem_init(32'h2000_0000));
      if (d_ack) exp_d.push_back(mem_init(32'h404));
    end
    @(posedge clk);
    #1;
    if_req = 0;
    d_req = 0;
    idle(2 * L + 6);
    exp_if.delete();
    exp_d.delete();
    chk(glog.size() >= 10, "starve_grants", glog.size(), 10);
    for (int i = 0; i < 10 && i < glog.size(); i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
      chk(glog[i] == (i % 5 != 4), "starve_pattern", 32'(glog[i]), 32'(i % 5 != 4));
`else
      chk(glog[i] == 1'b1, "strict_prio", 32'(glog[i]), 1);
`endif
    end
    fork
      repeat (30) begin
        idle($urandom_range(0, 3));
        if_addr = 32'h1000_0000 | ($urandom & 32'hFFFC);
        if_req = 1;
        exp_if.push_back(mem_init(if_addr));
        wait_ack(0);
        if_req = 0;
      end
      repeat (30) begin
        idle($urandom_range(1, 3));
        push_d(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
        wait_ack(1);
        d_req = 0;
      end
    join
    idle(2 * L + 6);
    chk(exp_if.size() == 0, "if_queue_drained", exp_if.size(), 0);
    chk(exp_d.size() == 0, "d_queue_drained", exp_d.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1);
  end
endmodule
